game_collision_scheduler: RTL and testbench
===========================================

# game_collision_scheduler

Time-multiplexed collision engine for the game core. It replaces the fully parallel pairwise comparator array with a single shared rectangle-overlap comparator that a state machine walks over every object pair once per frame. Each scan is started by a frame tick, and the scheduler publishes registered hit masks that the object managers consume before the next frame.

## Interface
- MAX_ENEMY, 4, enemy slots
- MAX_ENEMY_BULLET, 8, enemy bullet slots
- MAX_PLAYER_BULLET, 4, player bullet slots
- BULLET_WIDTH / BULLET_HEIGHT, 8 / 8, bullet box size (px)
- ENEMY_WIDTH / ENEMY_HEIGHT, 32 / 32, enemy box size
- PLAYER_WIDTH / PLAYER_HEIGHT, 32 / 32, player box size
- PLAYER_CENTER_Y, 440, fixed player y (9 bit)

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous, active-high reset
- i_Start  in  1  frame tick; one-cycle pulse requests a scan
- i_PlayerX  in  10  player x
- i_PlayerBulletPos  in  19*MAX_PLAYER_BULLET  packed {x[9:0], y[8:0]}; slot k at bits [19k+18:19k]
- i_PlayerBulletValid  in  MAX_PLAYER_BULLET  slot active
- i_EnemyPos  in  19*MAX_ENEMY  packed, same layout
- i_EnemyValid  in  MAX_ENEMY
- i_EnemyBulletPos  in  19*MAX_ENEMY_BULLET  packed, same layout
- i_EnemyBulletValid  in  MAX_ENEMY_BULLET
- o_Busy  out  1  scan in progress
- o_Done  out  1  one-cycle pulse; hit outputs updated
- o_PlayerBulletHit  out  MAX_PLAYER_BULLET
- o_EnemyHit  out  MAX_ENEMY
- o_EnemyBulletHit  out  MAX_ENEMY_BULLET
- o_PlayerHit  out  1

## Operation
- States: IDLE, PB_EN, PB_EB, EB_PL, DONE.
- IDLE with i_Start=1: snapshot all position and valid inputs, clear the accumulators, zero the indices, and go to PB_EN. i_Start in any other state is ignored.
- Input changes after the snapshot do not affect the current scan.
- PB_EN: one pair per cycle, with player bullet k as the outer index and enemy m as the inner index.
  - A hit requires both entries valid and the boxes overlapping.
  - On a hit, set pbHit[k] and enHit[m].
- PB_EB: pairs (k, enemy bullet l), same index order. On a hit, set pbHit[k] and ebHit[l].
- EB_PL: enemy bullet l against the player box at (i_PlayerX snapshot, PLAYER_CENTER_Y). The player is always valid. On a hit, set ebHit[l] and playerHit.
- Index advance: the inner index increments each cycle. When it reaches its maximum, it wraps to 0 and the outer index increments. When both indices are at maximum, zero them and enter the next phase.
- After the last EB_PL pair the machine enters DONE. DONE copies the accumulators to the outputs, pulses o_Done and returns to IDLE.
- Overlap rule for A versus B: hit = !(Ax+AW <= Bx || Ax >= Bx+BW) && !(Ay+AH <= By || Ay >= By+BH).
  - Sums are computed at 11 bits (x) and 10 bits (y). No wraparound.
  - Edge-touching boxes do not collide.
- Accumulators OR-in hits, so multiple hits on one slot are idempotent.
- Hit outputs hold their value until the next o_Done.
- Reset (asynchronous, any state including mid-scan):
  - state = IDLE; indices, accumulators and all outputs = 0.
  - An aborted scan produces no o_Done.

## Timing
- N = MAX_PLAYER_BULLET*MAX_ENEMY + MAX_PLAYER_BULLET*MAX_ENEMY_BULLET + MAX_ENEMY_BULLET. N = 56 with default parameters.
- i_Start is sampled at edge T0. The snapshot is taken at T0 and o_Busy rises at T0.
- Pair j (0-based) is evaluated in the cycle after T_j. Its accumulator update occurs at T_{j+1}.
- At T_N, state = DONE. At T_{N+1}, outputs are registered, o_Done=1 and o_Busy=0. Start-to-Done = N+1 = 57 cycles with defaults.
- At T_{N+2}, o_Done=0. The earliest accepted next i_Start is at T_{N+2}. A start at T_{N+1} is ignored.
- Comparator: combinational on the registered snapshot and indices. No pipeline stage is inside the scan.

## Test plan
1. Reset: assert i_Rst with no clock edge → o_Busy, o_Done, all hit masks and o_PlayerHit are 0 immediately.
2. Enemy hit:
   - Stimulus: PB0 at (100,200) valid; EN2 at (95,190) valid; all else invalid; pulse i_Start.
   - Response: o_Done exactly 57 cycles later; o_PlayerBulletHit=4'b0001, o_EnemyHit=4'b0100, other outputs 0.
3. Bullet-versus-bullet edge case:
   - Stimulus: EB3 at (200,100), PB1 at (208,100), both valid.
   - Response: no hit. With PB1 moved to (207,100): o_PlayerBulletHit=4'b0010 and o_EnemyBulletHit=8'b0000_1000.
4. Player hit:
   - Stimulus: i_PlayerX=300, EB5 at (310,436) valid.
   - Response: o_PlayerHit=1, o_EnemyBulletHit=8'b0010_0000. With EB5 at (332,436): no hit.
5. Masking and snapshot:
   - An overlapping PB0/EN0 pair with i_EnemyValid=0 produces no hits.
   - Changing inputs to an overlapping valid pair 5 cycles after the start leaves the results at all-zero.
   - A second i_Start pulse during the scan does not alter the Done timing.
6. Reset mid-scan:
   - Stimulus: assert i_Rst 20 cycles after start.
   - Response: o_Busy=0 and no o_Done. A fresh start afterwards completes in 57 cycles with correct masks.

Source files
------------

// File: rtl/game_collision_scheduler.sv
// Time-multiplexed collision engine: one shared rectangle-overlap comparator
// walks every object pair once per frame and publishes registered hit masks.
module game_collision_scheduler #(
  parameter int unsigned MAX_ENEMY         = 4,
  parameter int unsigned MAX_ENEMY_BULLET  = 8,
  parameter int unsigned MAX_PLAYER_BULLET = 4,
  parameter int unsigned BULLET_WIDTH      = 8,
  parameter int unsigned BULLET_HEIGHT     = 8,
  parameter int unsigned ENEMY_WIDTH       = 32,
  parameter int unsigned ENEMY_HEIGHT      = 32,
  parameter int unsigned PLAYER_WIDTH      = 32,
  parameter int unsigned PLAYER_HEIGHT     = 32,
  parameter int unsigned PLAYER_CENTER_Y   = 440
) (
  input  logic                            i_Clk,
  input  logic                            i_Rst,
  input  logic                            i_Start,
  input  logic [9:0]                      i_PlayerX,
  input  logic [19*MAX_PLAYER_BULLET-1:0] i_PlayerBulletPos,
  input  logic [MAX_PLAYER_BULLET-1:0]    i_PlayerBulletValid,
  input  logic [19*MAX_ENEMY-1:0]         i_EnemyPos,
  input  logic [MAX_ENEMY-1:0]            i_EnemyValid,
  input  logic [19*MAX_ENEMY_BULLET-1:0]  i_EnemyBulletPos,
  input  logic [MAX_ENEMY_BULLET-1:0]     i_EnemyBulletValid,
  output logic                            o_Busy,
  output logic                            o_Done,
  output logic [MAX_PLAYER_BULLET-1:0]    o_PlayerBulletHit,
  output logic [MAX_ENEMY-1:0]            o_EnemyHit,
  output logic [MAX_ENEMY_BULLET-1:0]     o_EnemyBulletHit,
  output logic                            o_PlayerHit
);
  localparam int unsigned PW = 19;
  localparam int unsigned IW = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PB_EN = 3'd1;
  localparam logic [2:0] S_PB_EB = 3'd2;
  localparam logic [2:0] S_EB_PL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                      state_q, state_d;
  logic [IW-1:0]                   outer_q, outer_d, inner_q, inner_d;
  logic [19*MAX_PLAYER_BULLET-1:0] pbPos_q;
  logic [MAX_PLAYER_BULLET-1:0]    pbVal_q;
  logic [19*MAX_ENEMY-1:0]         enPos_q;
  logic [MAX_ENEMY-1:0]            enVal_q;
  logic [19*MAX_ENEMY_BULLET-1:0]  ebPos_q;
  logic [MAX_ENEMY_BULLET-1:0]     ebVal_q;
  logic [9:0]                      plX_q;
  logic [MAX_PLAYER_BULLET-1:0]    pbAcc_q, pbAcc_d, pbOut_q, pbOut_d;
  logic [MAX_ENEMY-1:0]            enAcc_q, enAcc_d, enOut_q, enOut_d;
  logic [MAX_ENEMY_BULLET-1:0]     ebAcc_q, ebAcc_d, ebOut_q, ebOut_d;
  logic                            plAcc_q, plAcc_d, plOut_q, plOut_d;
  logic                            done_q, done_d;
  logic                            snap;

  // Shared comparator operands, selected by phase and indices.
  logic [9:0]   ax, bx;
  logic [8:0]   ay, by;
  logic [10:0]  aw, bw;
  logic [9:0]   ah, bh;
  logic         pair_valid, hit;
  int unsigned  oi, ii;

  assign oi = 32'(outer_q);
  assign ii = 32'(inner_q);

  always_comb begin
    ax = '0; ay = '0; aw = '0; ah = '0;
    bx = '0; by = '0; bw = '0; bh = '0;
    pair_valid = 1'b0;
    case (state_q)
      S_PB_EN: begin
        ax = pbPos_q[PW*oi+9 +: 10]; ay = pbPos_q[PW*oi +: 9];
        bx = enPos_q[PW*ii+9 +: 10]; by = enPos_q[PW*ii +: 9];
        aw = 11'(BULLET_WIDTH); ah = 10'(BULLET_HEIGHT);
        bw = 11'(ENEMY_WIDTH);  bh = 10'(ENEMY_HEIGHT);
        pair_valid = pbVal_q[oi] & enVal_q[ii];
      end
      S_PB_EB: begin
        ax = pbPos_q[PW*oi+9 +: 10]; ay = pbPos_q[PW*oi +: 9];
        bx = ebPos_q[PW*ii+9 +: 10]; by = ebPos_q[PW*ii +: 9];
        aw = 11'(BULLET_WIDTH); ah = 10'(BULLET_HEIGHT);
        bw = 11'(BULLET_WIDTH); bh = 10'(BULLET_HEIGHT);
        pair_valid = pbVal_q[oi] & ebVal_q[ii];
      end
      S_EB_PL: begin
        ax = ebPos_q[PW*ii+9 +: 10]; ay = ebPos_q[PW*ii +: 9];
        bx = plX_q; by = 9'(PLAYER_CENTER_Y);
        aw = 11'(BULLET_WIDTH); ah = 10'(BULLET_HEIGHT);
        bw = 11'(PLAYER_WIDTH); bh = 10'(PLAYER_HEIGHT);
        pair_valid = ebVal_q[ii];
      end
      default: ;
    endcase
  end

  // Widened sums so boxes near the screen edge never wrap; touching edges miss.
  assign hit = pair_valid
    && !(({1'b0, ax} + aw <= {1'b0, bx}) || ({1'b0, ax} >= {1'b0, bx} + bw))
    && !(({1'b0, ay} + ah <= {1'b0, by}) || ({1'b0, ay} >= {1'b0, by} + bh));

  assign snap = (state_q == S_IDLE) && i_Start;

  always_comb begin
    logic [IW-1:0] inner_max, outer_max;
    logic [2:0]    next_phase;
    state_d = state_q;
    outer_d = outer_q;
    inner_d = inner_q;
    pbAcc_d = pbAcc_q; enAcc_d = enAcc_q; ebAcc_d = ebAcc_q; plAcc_d = plAcc_q;
    pbOut_d = pbOut_q; enOut_d = enOut_q; ebOut_d = ebOut_q; plOut_d = plOut_q;
    done_d  = 1'b0;
    inner_max  = '0;
    outer_max  = '0;
    next_phase = S_DONE;
    case (state_q)
      S_PB_EN: begin
        inner_max = IW'(MAX_ENEMY - 1); outer_max = IW'(MAX_PLAYER_BULLET - 1);
        next_phase = S_PB_EB;
        if (hit) begin pbAcc_d[oi] = 1'b1; enAcc_d[ii] = 1'b1; end
      end
      S_PB_EB: begin
        inner_max = IW'(MAX_ENEMY_BULLET - 1); outer_max = IW'(MAX_PLAYER_BULLET - 1);
        next_phase = S_EB_PL;
        if (hit) begin pbAcc_d[oi] = 1'b1; ebAcc_d[ii] = 1'b1; end
      end
      S_EB_PL: begin
        inner_max = IW'(MAX_ENEMY_BULLET - 1); outer_max = '0;
        next_phase = S_DONE;
        if (hit) begin ebAcc_d[ii] = 1'b1; plAcc_d = 1'b1; end
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: if (i_Start) begin
        state_d = S_PB_EN;
        outer_d = '0; inner_d = '0;
        pbAcc_d = '0; enAcc_d = '0; ebAcc_d = '0; plAcc_d = 1'b0;
      end
      S_PB_EN, S_PB_EB, S_EB_PL: begin
        if (inner_q == inner_max) begin
          inner_d = '0;
          if (outer_q == outer_max) begin
            outer_d = '0;
            state_d = next_phase;
          end else begin
            outer_d = outer_q + 1'b1;
          end
        end else begin
          inner_d = inner_q + 1'b1;
        end
      end
      S_DONE: begin
        pbOut_d = pbAcc_q; enOut_d = enAcc_q; ebOut_d = ebAcc_q; plOut_d = plAcc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      outer_q <= '0; inner_q <= '0;
      pbPos_q <= '0; pbVal_q <= '0;
      enPos_q <= '0; enVal_q <= '0;
      ebPos_q <= '0; ebVal_q <= '0;
      plX_q   <= '0;
      pbAcc_q <= '0; enAcc_q <= '0; ebAcc_q <= '0; plAcc_q <= 1'b0;
      pbOut_q <= '0; enOut_q <= '0; ebOut_q <= '0; plOut_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      outer_q <= outer_d; inner_q <= inner_d;
      if (snap) begin
        pbPos_q <= i_PlayerBulletPos; pbVal_q <= i_PlayerBulletValid;
        enPos_q <= i_EnemyPos;        enVal_q <= i_EnemyValid;
        ebPos_q <= i_EnemyBulletPos;  ebVal_q <= i_EnemyBulletValid;
        plX_q   <= i_PlayerX;
      end
      pbAcc_q <= pbAcc_d; enAcc_q <= enAcc_d; ebAcc_q <= ebAcc_d; plAcc_q <= plAcc_d;
      pbOut_q <= pbOut_d; enOut_q <= enOut_d; ebOut_q <= ebOut_d; plOut_q <= plOut_d;
      done_q  <= done_d;
    end
  end

  assign o_Busy            = (state_q != S_IDLE);
  assign o_Done            = done_q;
  assign o_PlayerBulletHit = pbOut_q;
  assign o_EnemyHit        = enOut_q;
  assign o_EnemyBulletHit  = ebOut_q;
  assign o_PlayerHit       = plOut_q;
endmodule

// File: tb/tb_game_collision_scheduler.sv
// Directed bench for game_collision_scheduler: expected masks are queued at
// each start and compared when o_Done fires, along with start-to-done latency.
module tb_game_collision_scheduler;
  localparam int unsigned LAT = 57;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  player_x = 10'd600;
  logic [75:0] pb_pos = '0;
  logic [3:0]  pb_val = '0;
  logic [75:0] en_pos = '0;
  logic [3:0]  en_val = '0;
  logic [151:0] eb_pos = '0;
  logic [7:0]  eb_val = '0;
  logic        busy, done, pl_hit;
  logic [3:0]  pb_hit, en_hit;
  logic [7:0]  eb_hit;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] pb;
    logic [3:0] en;
    logic [7:0] eb;
    logic       pl;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  game_collision_scheduler dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_PlayerX(player_x),
    .i_PlayerBulletPos(pb_pos), .i_PlayerBulletValid(pb_val),
    .i_EnemyPos(en_pos), .i_EnemyValid(en_val),
    .i_EnemyBulletPos(eb_pos), .i_EnemyBulletValid(eb_val),
    .o_Busy(busy), .o_Done(done),
    .o_PlayerBulletHit(pb_hit), .o_EnemyHit(en_hit),
    .o_EnemyBulletHit(eb_hit), .o_PlayerHit(pl_hit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    pb_pos = '0; pb_val = '0; en_pos = '0; en_val = '0;
    eb_pos = '0; eb_val = '0; player_x = 10'd600;
  endtask

  task automatic set_pb(input int k, input int x, input int y, input logic v);
    pb_pos[19*k +: 19] = {10'(x), 9'(y)}; pb_val[k] = v;
  endtask
  task automatic set_en(input int k, input int x, input int y, input logic v);
    en_pos[19*k +: 19] = {10'(x), 9'(y)}; en_val[k] = v;
  endtask
  task automatic set_eb(input int k, input int x, input int y, input logic v);
    eb_pos[19*k +: 19] = {10'(x), 9'(y)}; eb_val[k] = v;
  endtask

  // Pulse start (sampled at T0) and queue the expected result.
  task automatic start_scan(input exp_t e);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    sb.push_back(e);
    check("busy_at_start", 32'(busy), 32'd1);
  endtask

  // Wait for o_Done (bounded); optionally re-pulse start or corrupt inputs mid-scan.
  task automatic wait_done(input string tag, input int extra_start_at, input bit corrupt_at5);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (corrupt_at5 && cyc == 5) begin
        set_pb(0, 100, 200, 1'b1);
        set_en(0, 95, 190, 1'b1);
      end
      if (cyc == extra_start_at) start = 1'b1;
      if (cyc == extra_start_at + 1) start = 1'b0;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_pb_hit"}, 32'(pb_hit), 32'(e.pb));
      check({tag, "_en_hit"}, 32'(en_hit), 32'(e.en));
      check({tag, "_eb_hit"}, 32'(eb_hit), 32'(e.eb));
      check({tag, "_pl_hit"}, 32'(pl_hit), 32'(e.pl));
    end else begin
      check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold_pb"}, 32'(pb_hit), 32'(e.pb));
  endtask

  initial begin
    exp_t e;
    int   seen;

    // Asynchronous reset, no clock edge yet
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pb", 32'(pb_hit), 32'd0);
    check("rst_en", 32'(en_hit), 32'd0);
    check("rst_eb", 32'(eb_hit), 32'd0);
    check("rst_pl", 32'(pl_hit), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Enemy hit
    clear_inputs();
    set_pb(0, 100, 200, 1'b1);
    set_en(2, 95, 190, 1'b1);
    e = '{pb: 4'b0001, en: 4'b0100, eb: 8'h00, pl: 1'b0};
    start_scan(e);
    wait_done("enemy_hit", -10, 1'b0);

    // Bullet vs bullet: touching edges miss
    clear_inputs();
    set_eb(3, 200, 100, 1'b1);
    set_pb(1, 208, 100, 1'b1);
    e = '{pb: 4'b0000, en: 4'b0000, eb: 8'h00, pl: 1'b0};
    start_scan(e);
    wait_done("bb_touch", -10, 1'b0);

    // One pixel of overlap hits
    set_pb(1, 207, 100, 1'b1);
    e = '{pb: 4'b0010, en: 4'b0000, eb: 8'b0000_1000, pl: 1'b0};
    start_scan(e);
    wait_done("bb_overlap", -10, 1'b0);

    // Player hit
    clear_inputs();
    player_x = 10'd300;
    set_eb(5, 310, 436, 1'b1);
    e = '{pb: 4'b0000, en: 4'b0000, eb: 8'b0010_0000, pl: 1'b1};
    start_scan(e);
    wait_done("player_hit", -10, 1'b0);

    set_eb(5, 332, 436, 1'b1);
    e = '{pb: 4'b0000, en: 4'b0000, eb: 8'h00, pl: 1'b0};
    start_scan(e);
    wait_done("player_edge", -10, 1'b0);

    // Invalid enemy masks an overlapping pair
    clear_inputs();
    set_pb(0, 100, 200, 1'b1);
    set_en(0, 95, 190, 1'b0);
    e = '{pb: 4'b0000, en: 4'b0000, eb: 8'h00, pl: 1'b0};
    start_scan(e);
    wait_done("masked", -10, 1'b0);

    // Inputs changed after the snapshot are ignored; a second start mid-scan too
    clear_inputs();
    e = '{pb: 4'b0000, en: 4'b0000, eb: 8'h00, pl: 1'b0};
    start_scan(e);
    wait_done("snapshot", 10, 1'b1);
    check("idle_after_restart", 32'(busy), 32'd0);

    // Reset mid-scan
    clear_inputs();
    set_pb(3, 50, 60, 1'b1);
    set_en(1, 40, 50, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    e = '{pb: 4'b1000, en: 4'b0010, eb: 8'h00, pl: 1'b0};
    start_scan(e);
    wait_done("after_rst", -10, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
